// File: rtl/alu_cmd_issuer_if.sv
// Bundles every signal the ALU command issuer exchanges with the outside world.
// slave modport: the issuer itself. master modport: upstream command source,
// response consumer and the combinational ALU, seen together from the far side.
// Ports: cmd_* command stream in, alu_* operands out / result in, rsp_* response stream out, busy.
interface alu_cmd_issuer_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_instruction;
  logic [WIDTH-1:0] cmd_operand_a;
  logic [WIDTH-1:0] cmd_operand_b;
  logic [TAG_W-1:0] cmd_tag;

  logic [2:0]       alu_instruction;
  logic [WIDTH-1:0] alu_operand_a;
  logic [WIDTH-1:0] alu_operand_b;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  logic             busy;

  modport master (
    output cmd_valid, cmd_instruction, cmd_operand_a, cmd_operand_b, cmd_tag,
    output alu_result,
    output rsp_ready,
    input  cmd_ready,
    input  alu_instruction, alu_operand_a, alu_operand_b,
    input  rsp_valid, rsp_data, rsp_tag, rsp_err,
    input  busy
  );

  modport slave (
    input  cmd_valid, cmd_instruction, cmd_operand_a, cmd_operand_b, cmd_tag,
    input  alu_result,
    input  rsp_ready,
    output cmd_ready,
    output alu_instruction, alu_operand_a, alu_operand_b,
    output rsp_valid, rsp_data, rsp_tag, rsp_err,
    output busy
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Purpose: buffers ALU commands in a FIFO, issues them one at a time to an external
//          combinational ALU, returns the captured result with its tag; screens divide-by-zero.
// Latency: accept->rsp_valid = SETTLE_CYCLES+1 cycles (1 cycle for divide-by-zero).
// Backpressure: cmd_ready = !full && !rst (no bypass when full); response held until rsp_ready.
// Ports: clk, rst (sync, active-high); bus (slave modport of alu_cmd_issuer_if).
module alu_cmd_issuer #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int TAG_W         = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_issuer_if.slave  bus
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = AW + 1;
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [2:0] OP_DIV = 3'b010;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  // ---------------- command FIFO ----------------
  cmd_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              full, empty, push, pop;
  cmd_t              push_cmd, head;

  assign full          = (fill_q == FILL_W'(DEPTH));
  assign empty         = (fill_q == '0);
  assign bus.cmd_ready = !full && !rst;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign push_cmd      = {bus.cmd_instruction, bus.cmd_operand_a, bus.cmd_operand_b, bus.cmd_tag};
  assign head          = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Storage needs no reset: entries are only read behind a valid fill count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_cmd;
  end

  // ---------------- issue FSM ----------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  cmd_t             alu_cmd_q, alu_cmd_d;   // zero outside DRIVE; carries the in-flight tag
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    alu_cmd_d   = alu_cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.op == OP_DIV && head.b == '0) begin
            // Never reaches the ALU: answer directly with an error response.
            rsp_valid_d = 1'b1;
            rsp_data_d  = '1;
            rsp_err_d   = 1'b1;
            rsp_tag_d   = head.tag;
            state_d     = RESP;
          end else begin
            alu_cmd_d = head;
            settle_d  = CNT_W'(SETTLE_CYCLES - 1);
            state_d   = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (settle_q != '0) begin
          settle_d = settle_q - CNT_W'(1);
        end else begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.alu_result;
          rsp_tag_d   = alu_cmd_q.tag;
          rsp_err_d   = 1'b0;
          alu_cmd_d   = '0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      state_q     <= IDLE;
      settle_q    <= '0;
      alu_cmd_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      settle_q    <= settle_d;
      alu_cmd_q   <= alu_cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.alu_instruction = alu_cmd_q.op;
  assign bus.alu_operand_a   = alu_cmd_q.a;
  assign bus.alu_operand_b   = alu_cmd_q.b;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_tag         = rsp_tag_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.busy            = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: models the combinational ALU, drives directed command
// sequences, and checks every response against a queue-based model of accepted commands.
module tb_alu_cmd_issuer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SETTLE = 1;
  localparam int TAG_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  alu_cmd_issuer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    case (op)
      3'd0: alu_f = a + b;
      3'd1: alu_f = a - b;
      3'd2: alu_f = (b == 8'd0) ? 8'hFF : a / b;
      3'd3: begin p = a * b; alu_f = p[7:0]; end
      3'd4: alu_f = a & b;
      3'd5: alu_f = a | b;
      3'd6: alu_f = ~a;
      default: alu_f = a ^ a;
    endcase
  endfunction

  // External ALU
  always_comb bus.alu_result = alu_f(bus.alu_instruction, bus.alu_operand_a, bus.alu_operand_b);

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] tag;
  } cmd_s;

  cmd_s       model_q[$];   // accepted, not yet answered, in acceptance order
  logic [7:0] got_q[$];     // data of every response handed over
  int n_cmp = 0;
  int n_bad = 0;
  int alu_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  logic       stall = 1'b0;
  logic [7:0] s_data;
  logic [1:0] s_tag;
  logic       s_err;

  always @(negedge clk) begin
    if (rst) begin
      model_q.delete();
      stall = 1'b0;
    end else begin
      chk("busy", {31'd0, bus.busy}, {31'd0, model_q.size() != 0});
      if (stall) begin
        chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("hold_data", {24'd0, bus.rsp_data}, {24'd0, s_data});
        chk("hold_tag", {30'd0, bus.rsp_tag}, {30'd0, s_tag});
        chk("hold_err", {31'd0, bus.rsp_err}, {31'd0, s_err});
      end
      if ({bus.alu_instruction, bus.alu_operand_a, bus.alu_operand_b} != 19'd0) begin
        alu_cycles++;
        chk("alu_during_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        if (model_q.size() == 0) begin
          chk("alu_idle", {13'd0, bus.alu_instruction, bus.alu_operand_a, bus.alu_operand_b}, 32'd0);
        end else begin
          chk("alu_ops", {13'd0, bus.alu_instruction, bus.alu_operand_a, bus.alu_operand_b},
              {13'd0, model_q[0].op, model_q[0].a, model_q[0].b});
          chk("alu_div0_issued", {31'd0, model_q[0].op == 3'd2 && model_q[0].b == 8'd0}, 32'd0);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (model_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got data 0x%0h tag %0d with nothing outstanding", bus.rsp_data, bus.rsp_tag);
        end else begin
          cmd_s c;
          logic div0;
          c = model_q.pop_front();
          div0 = (c.op == 3'd2) && (c.b == 8'd0);
          chk("rsp_data", {24'd0, bus.rsp_data}, {24'd0, div0 ? 8'hFF : alu_f(c.op, c.a, c.b)});
          chk("rsp_tag", {30'd0, bus.rsp_tag}, {30'd0, c.tag});
          chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, div0});
        end
        got_q.push_back(bus.rsp_data);
      end
      stall  = bus.rsp_valid && !bus.rsp_ready;
      s_data = bus.rsp_data;
      s_tag  = bus.rsp_tag;
      s_err  = bus.rsp_err;
      if (bus.cmd_valid && bus.cmd_ready)
        model_q.push_back('{op: bus.cmd_instruction, a: bus.cmd_operand_a, b: bus.cmd_operand_b, tag: bus.cmd_tag});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [1:0] tag);
    bit ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_instruction = op;
    bus.cmd_operand_a = a;
    bus.cmd_operand_b = b;
    bus.cmd_tag = tag;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!bus.busy) ok = 1'b1;
    end
    chk("idle_reached", {31'd0, ok}, 32'd1);
  endtask

  task automatic chk_alu_zero(input string name);
    chk(name, {13'd0, bus.alu_instruction, bus.alu_operand_a, bus.alu_operand_b}, 32'd0);
  endtask

  initial begin
    #1000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int ac;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_instruction = 3'd0;
    bus.cmd_operand_a = 8'd0;
    bus.cmd_operand_b = 8'd0;
    bus.cmd_tag = 2'd0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
    chk("reset_rsp_tag", {30'd0, bus.rsp_tag}, 32'd0);
    chk("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk_alu_zero("reset_alu");

    // add 3+5, tag 1: operands for exactly one cycle, response two cycles after acceptance
    step();
    ac = alu_cycles;
    send(3'd0, 8'd3, 8'd5, 2'd1);
    @(negedge clk);
    chk_alu_zero("add_alu_before_issue");
    chk("add_valid_early", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("add_alu", {13'd0, bus.alu_instruction, bus.alu_operand_a, bus.alu_operand_b}, {13'd0, 3'd0, 8'd3, 8'd5});
    chk("add_valid_drive", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("add_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("add_data", {24'd0, bus.rsp_data}, 32'h08);
    chk("add_tag", {30'd0, bus.rsp_tag}, 32'd1);
    chk("add_err", {31'd0, bus.rsp_err}, 32'd0);
    chk_alu_zero("add_alu_after");
    wait_idle();
    chk("add_alu_cycles", alu_cycles - ac, 32'd1);

    // mul 16x17 then sub 5-6, back to back
    step();
    base = got_q.size();
    ac = alu_cycles;
    send(3'd3, 8'd16, 8'd17, 2'd0);
    send(3'd1, 8'd5, 8'd6, 2'd3);
    wait_idle();
    chk("b2b_count", got_q.size() - base, 32'd2);
    chk("mul_data", {24'd0, got_q[base]}, 32'h10);
    chk("sub_data", {24'd0, got_q[base + 1]}, 32'hFF);
    chk("b2b_alu_cycles", alu_cycles - ac, 32'd2);

    // div 200/0, tag 2: error response one cycle after acceptance, ALU never driven
    step();
    ac = alu_cycles;
    send(3'd2, 8'd200, 8'd0, 2'd2);
    @(negedge clk);
    chk("div0_valid_early", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("div0_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("div0_data", {24'd0, bus.rsp_data}, 32'hFF);
    chk("div0_err", {31'd0, bus.rsp_err}, 32'd1);
    chk("div0_tag", {30'd0, bus.rsp_tag}, 32'd2);
    chk_alu_zero("div0_alu");
    wait_idle();
    chk("div0_alu_cycles", alu_cycles - ac, 32'd0);

    // div 200/7
    step();
    base = got_q.size();
    send(3'd2, 8'd200, 8'd7, 2'd3);
    wait_idle();
    chk("div_data", {24'd0, got_q[base]}, 32'd28);

    // Backpressure: six commands with rsp_ready low
    step();
    base = got_q.size();
    bus.rsp_ready = 1'b0;
    send(3'd4, 8'hF0, 8'h3C, 2'd0);
    send(3'd5, 8'h0F, 8'h30, 2'd1);
    send(3'd6, 8'h5A, 8'h00, 2'd2);
    send(3'd7, 8'h77, 8'h12, 2'd3);
    send(3'd0, 8'hFF, 8'h02, 2'd0);
    @(negedge clk);
    chk("full_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
    step();
    bus.cmd_valid = 1'b1;
    bus.cmd_instruction = 3'd1;
    bus.cmd_operand_a = 8'h10;
    bus.cmd_operand_b = 8'h20;
    bus.cmd_tag = 2'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      chk("stall_data", {24'd0, bus.rsp_data}, 32'h30);
    end
    step();
    bus.rsp_ready = 1'b1;
    send(3'd1, 8'h10, 8'h20, 2'd1);
    wait_idle();
    chk("drain_count", got_q.size() - base, 32'd6);
    chk("drain_0", {24'd0, got_q[base]}, 32'h30);
    chk("drain_1", {24'd0, got_q[base + 1]}, 32'h3F);
    chk("drain_2", {24'd0, got_q[base + 2]}, 32'hA5);
    chk("drain_3", {24'd0, got_q[base + 3]}, 32'h00);
    chk("drain_4", {24'd0, got_q[base + 4]}, 32'h01);
    chk("drain_5", {24'd0, got_q[base + 5]}, 32'hF0);

    // Reset while a command is in DRIVE with two more queued
    step();
    base = got_q.size();
    bus.rsp_ready = 1'b0;
    send(3'd0, 8'd1, 8'd2, 2'd0);
    send(3'd0, 8'h10, 8'h01, 2'd1);
    send(3'd1, 8'h20, 8'h01, 2'd2);
    send(3'd3, 8'h03, 8'h03, 2'd3);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rstmid_alu", {13'd0, bus.alu_instruction, bus.alu_operand_a, bus.alu_operand_b}, {13'd0, 3'd0, 8'h10, 8'h01});
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstmid_cmd_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    chk_alu_zero("rstmid_alu_zero");
    chk("rstmid_first_rsp", {24'd0, got_q[base]}, 32'd3);
    repeat (10) @(negedge clk);
    chk("rstmid_no_stale", got_q.size() - base, 32'd1);

    // Still operational after the mid-operation reset
    step();
    base = got_q.size();
    send(3'd0, 8'd1, 8'd1, 2'd1);
    wait_idle();
    chk("post_rst_data", {24'd0, got_q[base]}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
